// File: rtl/udp_gateway_initiator.sv
// Batches local-bus commands into one mem_gateway UDP payload, streams it into a byte client and
// turns the echoed reply into per-transaction responses; cmd_ready is low while a packet is out.
module udp_gateway_initiator #(
  parameter int n_lat     = 10,
  parameter int n_hdr     = 42,
  parameter int max_trans = 8,
  parameter int n_gap     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_last,
  output logic [10:0] len_c,
  output logic [7:0]  idata,
  output logic        raw_l,
  output logic        raw_s,
  input  logic [7:0]  odata,
  output logic        rsp_valid,
  output logic        rsp_rnw,
  output logic [31:0] rsp_data,
  output logic        hdr_err,
  output logic        busy
);

  localparam int AW  = (max_trans > 1) ? $clog2(max_trans) : 1;
  localparam int CW  = $clog2(max_trans + 1);
  localparam int IW  = $clog2(8 + 8 * max_trans);
  localparam int TMW = $clog2(((n_hdr > n_gap) ? n_hdr : n_gap) + 1);

  typedef enum logic [1:0] {FILL, HDR, PAY, GAP} state_t;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [IW-1:0] idx;
    logic [7:0]    dat;
  } tag_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [10:0]    len_q, len_d;
  logic [TMW-1:0] tmr_q, tmr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [63:0]    nonce_q, nonce_d;
  logic           wr_en;
  logic           pend_inc;

  logic           rnw_mem  [max_trans];
  logic [23:0]    addr_mem [max_trans];
  logic [31:0]    data_mem [max_trans];

  logic [IW-1:0]  off;
  logic [AW-1:0]  ent;
  logic [IW-1:0]  pay_last;
  logic           pay_end;
  logic [7:0]     pay_byte;

  tag_t           tag_in;
  tag_t           dl_q [n_lat];
  tag_t           smp_q;
  logic [7:0]     smp_dat_q;

  logic           herr_acc_q, herr_acc_d;
  logic           hdr_err_q, hdr_err_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_rnw_q, rsp_rnw_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic [23:0]    shift_q, shift_d;
  logic [2:0]     pend_q, pend_d;
  logic           pend_dec;
  logic           mism;

  assign pay_last = IW'({cnt_q, 3'b111});
  assign pay_end  = (state_q == PAY) && (idx_q == pay_last);

  // Payload byte mux: 8 nonce bytes, then 8 bytes per buffered transaction.
  always_comb begin
    off      = idx_q - IW'(8);
    ent      = AW'(off >> 3);
    pay_byte = 8'h00;
    if (idx_q < IW'(8)) begin
      pay_byte = nonce_q[{~idx_q[2:0], 3'b000} +: 8];
    end else begin
      case (idx_q[2:0])
        3'd0:    pay_byte = rnw_mem[ent] ? 8'h10 : 8'h00;
        3'd1:    pay_byte = addr_mem[ent][23:16];
        3'd2:    pay_byte = addr_mem[ent][15:8];
        3'd3:    pay_byte = addr_mem[ent][7:0];
        default: pay_byte = rnw_mem[ent] ? 8'h00 : data_mem[ent][{~idx_q[1:0], 3'b000} +: 8];
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    tmr_d     = tmr_q;
    idx_d     = idx_q;
    nonce_d   = nonce_q;
    wr_en     = 1'b0;
    pend_inc  = 1'b0;
    cmd_ready = 1'b0;
    raw_l     = 1'b0;
    raw_s     = 1'b0;
    idata     = 8'h00;
    case (state_q)
      FILL: begin
        cmd_ready = (cnt_q != CW'(max_trans));
        if (cmd_valid && cmd_ready) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cmd_last || (cnt_q == CW'(max_trans - 1))) begin
            state_d  = HDR;
            len_d    = 11'(16 + 8 * (int'(cnt_q) + 1));
            tmr_d    = '0;
            pend_inc = 1'b1;
          end
        end
      end
      HDR: begin
        raw_l = 1'b1;
        if (tmr_q == TMW'(n_hdr - 1)) begin
          state_d = PAY;
          idx_d   = '0;
        end else begin
          tmr_d = tmr_q + TMW'(1);
        end
      end
      PAY: begin
        raw_l = 1'b1;
        raw_s = 1'b1;
        idata = pay_byte;
        if (pay_end) begin
          state_d = GAP;
          tmr_d   = '0;
          nonce_d = nonce_q + 64'd1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        if (tmr_q == TMW'(n_gap - 1)) begin
          state_d = FILL;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + TMW'(1);
        end
      end
    endcase
  end

  // The tag carries the byte actually sent, so header checks never depend on the live nonce.
  assign tag_in = {raw_s, pay_end, idx_q, idata};

  always_comb begin
    hdr_err_d   = 1'b0;
    herr_acc_d  = herr_acc_q;
    rsp_valid_d = 1'b0;
    rsp_rnw_d   = rsp_rnw_q;
    rsp_data_d  = rsp_data_q;
    shift_d     = shift_q;
    pend_dec    = 1'b0;
    mism        = 1'b0;
    if (smp_q.vld) begin
      if (smp_q.idx < IW'(8)) begin
        mism = (smp_dat_q != smp_q.dat);
        if (smp_q.idx[2:0] == 3'd7) begin
          hdr_err_d  = herr_acc_q | mism;
          herr_acc_d = 1'b0;
        end else begin
          herr_acc_d = herr_acc_q | mism;
        end
      end else begin
        case (smp_q.idx[2:0])
          3'd0:                rsp_rnw_d = smp_dat_q[4];
          3'd4, 3'd5, 3'd6:    shift_d   = {shift_q[15:0], smp_dat_q};
          3'd7: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = {shift_q, smp_dat_q};
          end
          default: ;
        endcase
      end
      pend_dec = smp_q.last;
    end
    pend_d = pend_q + {2'b00, pend_inc} - {2'b00, pend_dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      len_q       <= '0;
      tmr_q       <= '0;
      idx_q       <= '0;
      nonce_q     <= '0;
      smp_q       <= '0;
      smp_dat_q   <= '0;
      herr_acc_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rnw_q   <= 1'b0;
      rsp_data_q  <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      for (int i = 0; i < n_lat; i++) dl_q[i] <= '0;
      for (int i = 0; i < max_trans; i++) begin
        rnw_mem[i]  <= 1'b0;
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      nonce_q     <= nonce_d;
      dl_q[0]     <= tag_in;
      for (int i = 1; i < n_lat; i++) dl_q[i] <= dl_q[i-1];
      smp_q       <= dl_q[n_lat-1];
      smp_dat_q   <= odata;
      herr_acc_q  <= herr_acc_d;
      hdr_err_q   <= hdr_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rnw_q   <= rsp_rnw_d;
      rsp_data_q  <= rsp_data_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      if (wr_en) begin
        rnw_mem[AW'(cnt_q)]  <= cmd_rnw;
        addr_mem[AW'(cnt_q)] <= cmd_addr;
        data_mem[AW'(cnt_q)] <= cmd_wdata;
      end
    end
  end

  assign len_c     = len_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rnw   = rsp_rnw_q;
  assign rsp_data  = rsp_data_q;
  assign hdr_err   = hdr_err_q;
  assign busy      = (state_q != FILL) || (pend_q != 3'd0);

endmodule

// File: tb/tb_udp_gateway_initiator.sv
// Directed bench: a mem_gateway-like echo client with scratch memory drives the initiator.
module tb_udp_gateway_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rnw = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_last = 1'b0;
  logic [10:0] len_c;
  logic [7:0]  idata;
  logic        raw_l, raw_s;
  logic [7:0]  odata;
  logic        rsp_valid, rsp_rnw, hdr_err, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  udp_gateway_initiator #(.n_lat(10), .n_hdr(42), .max_trans(8), .n_gap(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_last(cmd_last),
    .len_c(len_c), .idata(idata), .raw_l(raw_l), .raw_s(raw_s), .odata(odata),
    .rsp_valid(rsp_valid), .rsp_rnw(rsp_rnw), .rsp_data(rsp_data),
    .hdr_err(hdr_err), .busy(busy)
  );

  // Echo client, 10-cycle latency; read data comes from a scratch memory.
  logic [7:0]  pipe [10];
  logic [31:0] mem  [256];
  bit          mem_w [256];
  int          cpos = 0;
  logic        c_rnw = 1'b0;
  logic [23:0] c_addr = '0;
  logic [31:0] c_wd = '0;
  bit          corrupt = 1'b0;
  assign odata = pipe[9];

  always @(posedge clk) begin
    logic [7:0]  r;
    logic [31:0] w;
    r = 8'h00;
    if (raw_s) begin
      r = idata;
      if (cpos < 8) begin
        if (corrupt && cpos == 3) r = idata ^ 8'hFF;
      end else begin
        w = mem_w[c_addr[7:0]] ? mem[c_addr[7:0]] : {24'hA50000, c_addr[7:0]};
        case (cpos % 8)
          0: c_rnw <= idata[4];
          1: c_addr[23:16] <= idata;
          2: c_addr[15:8] <= idata;
          3: c_addr[7:0] <= idata;
          4, 5, 6: begin
            if (c_rnw) r = w[8*(7 - (cpos % 8)) +: 8];
            c_wd <= {c_wd[23:0], idata};
          end
          default: begin
            if (c_rnw) r = w[7:0];
            else begin
              mem[c_addr[7:0]]   <= {c_wd[23:0], idata};
              mem_w[c_addr[7:0]] <= 1'b1;
            end
          end
        endcase
      end
      cpos <= cpos + 1;
    end else if (!raw_l) begin
      cpos <= 0;
    end
    pipe[0] <= r;
    for (int i = 1; i < 10; i++) pipe[i] <= pipe[i-1];
  end

  // Passive monitor of packets and responses.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          pkt = 0, hcnt = 0, pcnt = 0;
  bit          pl = 1'b0, ps = 1'b0;
  int          hdr_len [8], pay_len [8], s_rise [8], s_fall [8], l_rise [8], lenc [8];
  logic [7:0]  pay [8][80];
  int          rsp_n = 0;
  logic [31:0] rsp_d [32];
  bit          rsp_r [32];
  int          rsp_c [32];
  int          herr_n = 0, herr_c = 0;

  always @(negedge clk) begin
    if (raw_l && !pl) begin l_rise[pkt] = cyc; hcnt = 0; end
    if (raw_l && !raw_s) hcnt++;
    if (raw_s && !ps) begin s_rise[pkt] = cyc; hdr_len[pkt] = hcnt; lenc[pkt] = int'(len_c); pcnt = 0; end
    if (raw_s) begin
      if (pcnt < 80) pay[pkt][pcnt] = idata;
      pcnt++;
    end
    if (!raw_s && ps) begin
      pay_len[pkt] = pcnt;
      s_fall[pkt]  = cyc;
      if (pkt < 7) pkt++;
    end
    if (rsp_valid && rsp_n < 32) begin
      rsp_d[rsp_n] = rsp_data; rsp_r[rsp_n] = rsp_rnw; rsp_c[rsp_n] = cyc; rsp_n++;
    end
    if (hdr_err) begin herr_n++; herr_c = cyc; end
    pl = raw_l;
    ps = raw_s;
  end

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit rnw, input logic [23:0] a, input logic [31:0] d, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_last = last;
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_n < n && k < 3000) begin @(negedge clk); k++; end
    chk("rsp_count", rsp_n, n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk("idle", busy, 0);
  endtask

  logic [7:0] e1 [16];
  int n0;

  initial begin
    e1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h01, 8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_len_c", len_c, 0);
    chk("rst_idata", idata, 0);
    chk("rst_raw_l", raw_l, 0);
    chk("rst_raw_s", raw_s, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rnw", rsp_rnw, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_hdr_err", hdr_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single write
    send(1'b0, 24'h000123, 32'hDEADBEEF, 1'b1);
    chk("t1_busy", busy, 1);
    wait_rsp(1);
    chk("t1_hdr_len", hdr_len[0], 42);
    chk("t1_pay_len", pay_len[0], 16);
    chk("t1_len_c", lenc[0], 24);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_byte%0d", i), pay[0][i], e1[i]);
    chk("t1_rsp_rnw", rsp_r[0], 0);
    chk("t1_rsp_data", rsp_d[0], 32'hDEADBEEF);
    chk("t1_rsp_lat", rsp_c[0] - s_rise[0], 27);
    wait_idle();

    // Three reads, nonce 1
    send(1'b1, 24'h000123, 32'h0, 1'b0);
    send(1'b1, 24'h000010, 32'h0, 1'b0);
    send(1'b1, 24'h000020, 32'h0, 1'b1);
    wait_rsp(4);
    chk("t2_len_c", lenc[1], 40);
    for (int i = 0; i < 7; i++) chk($sformatf("t2_nonce%0d", i), pay[1][i], 0);
    chk("t2_nonce7", pay[1][7], 8'h01);
    chk("t2_ctrl0", pay[1][8], 8'h10);
    chk("t2_rd_data_byte", pay[1][12], 8'h00);
    chk("t2_r1_rnw", rsp_r[1], 1);
    chk("t2_r1", rsp_d[1], 32'hDEADBEEF);
    chk("t2_r2", rsp_d[2], 32'hA5000010);
    chk("t2_r3", rsp_d[3], 32'hA5000020);
    chk("t2_hdr_err", herr_n, 0);
    wait_idle();

    // Eight commands, implicit last, then a 9th back-to-back
    for (int i = 0; i < 8; i++) send(1'b0, 24'h000040 + 24'(i), 32'h11111111 * 32'(i + 1), 1'b0);
    chk("t3_ready_low", cmd_ready, 0);
    send(1'b1, 24'h000043, 32'h0, 1'b1);
    chk("t3_accept_after_gap", acc_cyc - s_fall[2], 4);
    wait_rsp(13);
    chk("t3_len_c", lenc[2], 80);
    chk("t3_pay_len", pay_len[2], 72);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_rnw%0d", i), rsp_r[4+i], 0);
      chk($sformatf("t3_data%0d", i), rsp_d[4+i], 32'h11111111 * 32'(i + 1));
    end
    chk("t3_overlap", l_rise[3] < rsp_c[11], 1);
    chk("t4_len_c", lenc[3], 24);
    chk("t4_nonce7", pay[3][7], 8'h03);
    chk("t4_rnw", rsp_r[12], 1);
    chk("t4_data", rsp_d[12], 32'h44444444);
    wait_idle();

    // Corrupted reply header
    corrupt = 1'b1;
    send(1'b0, 24'h000055, 32'h01020304, 1'b1);
    wait_rsp(14);
    wait_idle();
    corrupt = 1'b0;
    chk("t5_hdr_err_cnt", herr_n, 1);
    chk("t5_hdr_err_cyc", herr_c - s_rise[4], 19);
    chk("t5_rsp", rsp_d[13], 32'h01020304);

    // Reset during PAY
    send(1'b0, 24'h000066, 32'hCAFEF00D, 1'b1);
    n0 = 0;
    while (!raw_s && n0 < 200) begin @(negedge clk); n0++; end
    chk("t6_pay_start", raw_s, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_raw_l", raw_l, 0);
    chk("t6_raw_s", raw_s, 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = rsp_n;
    repeat (60) @(negedge clk);
    chk("t6_no_rsp", rsp_n, n0);
    chk("t6_busy", busy, 0);
    send(1'b1, 24'h000066, 32'h0, 1'b1);
    wait_rsp(15);
    for (int i = 0; i < 8; i++) chk($sformatf("t6_nonce%0d", i), pay[6][i], 0);
    chk("t6_rnw", rsp_r[14], 1);
    chk("t6_data", rsp_d[14], 32'hA5000066);
    wait_idle();
    chk("final_rsp_total", rsp_n, 15);
    chk("final_hdr_err", herr_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
